// File: rtl/game_sprite_engine_pkg.sv
// -----------------------------------------------------------------------------
// game_sprite_engine_pkg
// Purpose : Constants shared by the sprite engines, the master FSM, the
//           collision detector and the mixer: screen size, position/velocity
//           and colour widths, and the colour palette.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package game_sprite_engine_pkg;

  localparam int DEF_SCREEN_W = 640;  // visible width in pixels
  localparam int DEF_SCREEN_H = 480;  // visible height in pixels
  localparam int DEF_POS_W    = 11;   // signed x/y position width
  localparam int DEF_D_W      = 4;    // signed dx/dy velocity width
  localparam int DEF_RGB_W    = 3;    // colour width
  localparam int PIX_W        = 10;   // display scan coordinate width
  localparam int BITMAP_DIM   = 8;    // bitmap masks are always 8x8, row-major

  localparam logic [DEF_RGB_W-1:0] RGB_BLACK = 3'b000;
  localparam logic [DEF_RGB_W-1:0] RGB_RED   = 3'b100;
  localparam logic [DEF_RGB_W-1:0] RGB_GREEN = 3'b010;
  localparam logic [DEF_RGB_W-1:0] RGB_BLUE  = 3'b001;

endpackage

// File: rtl/game_sprite_engine_if.sv
// -----------------------------------------------------------------------------
// game_sprite_engine_if
// Purpose : Bundles the command, scan and result signals between the master
//           side (game FSM + display scan) and one sprite engine.
// Signals : write_xy, write_dxy, enable_update  - command pulses/levels
//           x_init, y_init, dx_init, dy_init    - command operands
//           pixel_x, pixel_y                    - display scan coordinates
//           x, y, within_screen                 - sprite state back to master
//           sprite_on, rgb                      - render result for mixer
// Handshake: there is no valid/ready pair. write_xy and write_dxy are
//           sampled on every rising edge and act when high (one cycle high =
//           one load); enable_update is a level that gates movement on the
//           engine's internal strobe. The engine is always ready, so the
//           master never waits.
// -----------------------------------------------------------------------------
interface game_sprite_engine_if
  import game_sprite_engine_pkg::*;
#(
  parameter int POS_W = DEF_POS_W,
  parameter int D_W   = DEF_D_W,
  parameter int RGB_W = DEF_RGB_W
);
  logic             write_xy;
  logic             write_dxy;
  logic             enable_update;
  logic [POS_W-1:0] x_init;
  logic [POS_W-1:0] y_init;
  logic [D_W-1:0]   dx_init;
  logic [D_W-1:0]   dy_init;
  logic [PIX_W-1:0] pixel_x;
  logic [PIX_W-1:0] pixel_y;
  logic [POS_W-1:0] x;
  logic [POS_W-1:0] y;
  logic             within_screen;
  logic             sprite_on;
  logic [RGB_W-1:0] rgb;

  modport master (
    output write_xy, write_dxy, enable_update,
    output x_init, y_init, dx_init, dy_init,
    output pixel_x, pixel_y,
    input  x, y, within_screen, sprite_on, rgb
  );

  modport slave (
    input  write_xy, write_dxy, enable_update,
    input  x_init, y_init, dx_init, dy_init,
    input  pixel_x, pixel_y,
    output x, y, within_screen, sprite_on, rgb
  );
endinterface

// File: rtl/game_strobe_gen.sv
// -----------------------------------------------------------------------------
// game_strobe_gen
// Purpose : Free-running divider. count runs 0..STROBE_DIV-1 and wraps;
//           strobe is high for the single cycle in which count is at its last
//           value, so the first strobe after reset release lands on the
//           STROBE_DIV-th rising edge.
// Ports   : clk     - clock
//           rst_n   - asynchronous active-low reset
//           strobe  - one-cycle pulse every STROBE_DIV cycles
// -----------------------------------------------------------------------------
module game_strobe_gen #(
  parameter int STROBE_DIV = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  output logic strobe
);
  localparam int CNT_W = (STROBE_DIV > 2) ? $clog2(STROBE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STROBE_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (count_q == LAST) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign strobe = (count_q == LAST);
endmodule

// File: rtl/game_sprite_engine.sv
// -----------------------------------------------------------------------------
// game_sprite_engine
// Purpose : Holds one sprite's position and velocity, obeys write_xy /
//           write_dxy / enable_update, steps the sprite on an internal strobe,
//           reports within_screen and renders the sprite against the scan.
// Ports   : clk      - clock
//           reset_n  - asynchronous active-low reset
//           bus      - game_sprite_engine_if.slave (commands, scan, results)
// Config  : GAME_SPRITE_BITMAP_EN - when defined, a render hit also requires
//           BITMAP[row*8+col]; otherwise the full rectangle is drawn.
// -----------------------------------------------------------------------------
module game_sprite_engine
  import game_sprite_engine_pkg::*;
#(
  parameter int               SCREEN_W   = DEF_SCREEN_W,
  parameter int               SCREEN_H   = DEF_SCREEN_H,
  parameter int               POS_W      = DEF_POS_W,
  parameter int               D_W        = DEF_D_W,
  parameter int               SPRITE_W   = 8,
  parameter int               SPRITE_H   = 8,
  parameter int               STROBE_DIV = 1048576,
  parameter int               RGB_W      = DEF_RGB_W,
  parameter logic [RGB_W-1:0] SPRITE_RGB = RGB_RED,
  parameter logic [63:0]      BITMAP     = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  game_sprite_engine_if.slave  bus
);
  // Visibility bounds in position width; the sprite counts as visible while
  // any of its pixels overlaps the screen.
  localparam logic signed [POS_W-1:0] X_MIN = POS_W'(-SPRITE_W);
  localparam logic signed [POS_W-1:0] Y_MIN = POS_W'(-SPRITE_H);
  localparam logic signed [POS_W-1:0] X_MAX = POS_W'(SCREEN_W);
  localparam logic signed [POS_W-1:0] Y_MAX = POS_W'(SCREEN_H);
  // Render offsets are one bit wider than a position so an unsigned scan
  // coordinate minus a signed position can never overflow.
  localparam logic signed [POS_W:0]   SPR_W_S = (POS_W+1)'(SPRITE_W);
  localparam logic signed [POS_W:0]   SPR_H_S = (POS_W+1)'(SPRITE_H);

  logic strobe;

  game_strobe_gen #(.STROBE_DIV(STROBE_DIV)) u_strobe (
    .clk    (clk),
    .rst_n  (reset_n),
    .strobe (strobe)
  );

  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [D_W-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic             within_q, within_d;
  logic             sprite_on_q, sprite_on_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  logic [POS_W-1:0] dx_ext, dy_ext;
  assign dx_ext = {{(POS_W-D_W){dx_q[D_W-1]}}, dx_q};
  assign dy_ext = {{(POS_W-D_W){dy_q[D_W-1]}}, dy_q};

  // Position and velocity. A load beats a step on the same edge, and a step
  // always uses the velocity held before this edge.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (bus.write_xy) begin
      x_d = bus.x_init;
      y_d = bus.y_init;
    end else if (strobe && bus.enable_update) begin
      x_d = x_q + dx_ext;
      y_d = y_q + dy_ext;
    end
    if (bus.write_dxy) begin
      dx_d = bus.dx_init;
      dy_d = bus.dy_init;
    end
    // Computed from the next position so the flag is coherent with x/y.
    within_d = ($signed(x_d) > X_MIN) && ($signed(x_d) < X_MAX) &&
               ($signed(y_d) > Y_MIN) && ($signed(y_d) < Y_MAX);
  end

  // Render against the current (registered) position.
  logic signed [POS_W:0] col, row;
  logic                  hit;

  always_comb begin
    col = $signed({{(POS_W+1-PIX_W){1'b0}}, bus.pixel_x}) - $signed({x_q[POS_W-1], x_q});
    row = $signed({{(POS_W+1-PIX_W){1'b0}}, bus.pixel_y}) - $signed({y_q[POS_W-1], y_q});
    hit = !col[POS_W] && (col < SPR_W_S) && !row[POS_W] && (row < SPR_H_S);
`ifdef GAME_SPRITE_BITMAP_EN
    hit = hit && BITMAP[{row[2:0], col[2:0]}];
`endif
    sprite_on_d = hit;
    rgb_d       = hit ? SPRITE_RGB : '0;
  end

`ifndef GAME_SPRITE_BITMAP_EN
  logic unused_bitmap;
  assign unused_bitmap = ^BITMAP;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      within_q    <= 1'b1;  // no spurious end-of-game before the first load
      sprite_on_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      within_q    <= within_d;
      sprite_on_q <= sprite_on_d;
      rgb_q       <= rgb_d;
    end
  end

  assign bus.x             = x_q;
  assign bus.y             = y_q;
  assign bus.within_screen = within_q;
  assign bus.sprite_on     = sprite_on_q;
  assign bus.rgb           = rgb_q;
endmodule

// File: tb/tb_game_sprite_engine.sv
// -----------------------------------------------------------------------------
// tb_game_sprite_engine
// Purpose : Drives game_sprite_engine with directed and random commands; a
//           behavioural model predicts every cycle's outputs into exp_q and a
//           monitor compares them after each rising edge. Directed checks pin
//           the scenarios of the movement, screen-edge, priority, render and
//           reset behaviour to absolute values.
// Config  : GAME_SPRITE_BITMAP_EN - bench passes a bitmap with bit 63 clear.
// -----------------------------------------------------------------------------
module tb_game_sprite_engine;
  import game_sprite_engine_pkg::*;

  localparam int          DIV       = 4;
  localparam int          PW        = 11;
  localparam logic [63:0] TB_BITMAP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam int          EW        = PW + PW + 1 + 1 + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  game_sprite_engine_if #(.POS_W(PW), .D_W(4), .RGB_W(3)) bus ();

  game_sprite_engine #(.STROBE_DIV(DIV), .BITMAP(TB_BITMAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  // staged inputs for the next cycle
  bit s_rst, s_wxy, s_wdxy, s_en;
  int s_x, s_y, s_dx, s_dy, s_px, s_py;

  // reference model state
  int m_x, m_y, m_dx, m_dy, m_cnt;

  function automatic int wrap(input int v);
    int r;
    r = v & 2047;
    if (r >= 1024) r = r - 2048;
    return r;
  endfunction

  function automatic int sx(input logic [PW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic bit visible(input int px, input int py);
    return (px > -8) && (px < 640) && (py > -8) && (py < 480);
  endfunction

  function automatic bit model_hit(input int px, input int py, input int ox, input int oy);
    int c, r;
    logic [63:0] bm;
    bit h;
    c = px - ox;
    r = py - oy;
    h = (c >= 0) && (c < 8) && (r >= 0) && (r < 8);
`ifdef GAME_SPRITE_BITMAP_EN
    bm = TB_BITMAP;
    if (h) h = bm[r*8 + c];
`else
    bm = '0;
`endif
    return h;
  endfunction

  function automatic logic [EW-1:0] pack(input int px, input int py, input bit w, input bit h);
    logic [31:0] ux, uy;
    ux = px;
    uy = py;
    return {ux[PW-1:0], uy[PW-1:0], w, h, (h ? 3'b100 : 3'b000)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    bit strobe, h;
    logic [31:0] ux, uy, udx, udy, upx, upy;
    @(negedge clk);
    ux = s_x; uy = s_y; udx = s_dx; udy = s_dy; upx = s_px; upy = s_py;
    reset_n           = s_rst;
    bus.write_xy      = s_wxy;
    bus.write_dxy     = s_wdxy;
    bus.enable_update = s_en;
    bus.x_init        = ux[PW-1:0];
    bus.y_init        = uy[PW-1:0];
    bus.dx_init       = udx[3:0];
    bus.dy_init       = udy[3:0];
    bus.pixel_x       = upx[9:0];
    bus.pixel_y       = upy[9:0];
    if (!s_rst) begin
      m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_cnt = 0;
      exp_q.push_back(pack(0, 0, 1'b1, 1'b0));
    end else begin
      strobe = (m_cnt == DIV - 1);
      m_cnt  = (m_cnt + 1) % DIV;
      h      = model_hit(s_px, s_py, m_x, m_y);
      if (s_wxy) begin
        m_x = wrap(s_x);
        m_y = wrap(s_y);
      end else if (strobe && s_en) begin
        m_x = wrap(m_x + m_dx);
        m_y = wrap(m_y + m_dy);
      end
      if (s_wdxy) begin
        m_dx = s_dx;
        m_dy = s_dy;
      end
      exp_q.push_back(pack(m_x, m_y, visible(m_x, m_y), h));
    end
    s_wxy  = 1'b0;
    s_wdxy = 1'b0;
  endtask

  // Run until a strobe cycle has been driven, then one more cycle so the step
  // is visible on the outputs when this returns.
  task automatic step();
    while (m_cnt != DIV - 1) tick();
    tick();
    tick();
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.x, bus.y, bus.within_screen, bus.sprite_on, bus.rgb};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: got x=%0d y=%0d win=%0b on=%0b rgb=%0d, expected x=%0d y=%0d win=%0b on=%0b rgb=%0d",
                   $time, sx(a[EW-1 -: PW]), sx(a[EW-PW-1 -: PW]), a[4], a[3], a[2:0],
                   sx(e[EW-1 -: PW]), sx(e[EW-PW-1 -: PW]), e[4], e[3], e[2:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_rgb;
    reset_n = 1'b0;
    bus.write_xy = 0; bus.write_dxy = 0; bus.enable_update = 0;
    bus.x_init = '0; bus.y_init = '0; bus.dx_init = '0; bus.dy_init = '0;
    bus.pixel_x = '0; bus.pixel_y = '0;
    s_rst = 0; s_wxy = 0; s_wdxy = 0; s_en = 0;
    s_x = 0; s_y = 0; s_dx = 0; s_dy = 0; s_px = 0; s_py = 0;
    m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_cnt = 0;

    repeat (3) tick();
    chk("reset_x", sx(bus.x), 0);
    chk("reset_y", sx(bus.y), 0);
    chk("reset_within", int'(bus.within_screen), 1);
    chk("reset_sprite_on", int'(bus.sprite_on), 0);
    chk("reset_rgb", int'(bus.rgb), 0);

    // Load on the release cycle; first step only on the 4th edge after release.
    s_rst = 1; s_en = 1;
    s_wxy = 1; s_x = 100; s_y = 50;
    s_wdxy = 1; s_dx = 3; s_dy = -2;
    tick();
    repeat (3) tick();
    chk("no_early_step_x", sx(bus.x), 100);
    tick();
    chk("first_step_x", sx(bus.x), 103);
    chk("first_step_y", sx(bus.y), 48);
    repeat (8) tick();
    chk("three_steps_x", sx(bus.x), 109);
    chk("three_steps_y", sx(bus.y), 44);

    // Right screen edge.
    s_en = 0; s_wxy = 1; s_x = 636; s_y = 100; s_wdxy = 1; s_dx = 3; s_dy = 0;
    tick(); tick();
    s_en = 1;
    step();
    chk("right_edge_x", sx(bus.x), 639);
    chk("right_edge_within", int'(bus.within_screen), 1);
    step();
    chk("off_right_x", sx(bus.x), 642);
    chk("off_right_within", int'(bus.within_screen), 0);

    // Top screen edge.
    s_en = 0; s_wxy = 1; s_x = 100; s_y = -7; s_wdxy = 1; s_dx = 0; s_dy = -1;
    tick(); tick();
    chk("top_edge_y", sx(bus.y), -7);
    chk("top_edge_within", int'(bus.within_screen), 1);
    s_en = 1;
    step();
    chk("off_top_y", sx(bus.y), -8);
    chk("off_top_within", int'(bus.within_screen), 0);

    // write_xy on a strobe cycle: the step is lost.
    s_en = 0; s_wdxy = 1; s_dx = 2; s_dy = 2;
    tick();
    s_en = 1;
    while (m_cnt != DIV - 1) tick();
    s_wxy = 1; s_x = 10; s_y = 10;
    tick(); tick();
    chk("load_beats_step_x", sx(bus.x), 10);
    chk("load_beats_step_y", sx(bus.y), 10);

    // write_dxy on a strobe cycle: the step uses the old velocity.
    while (m_cnt != DIV - 1) tick();
    s_wdxy = 1; s_dx = 5; s_dy = -3;
    tick(); tick();
    chk("old_dx_used_x", sx(bus.x), 12);
    chk("old_dy_used_y", sx(bus.y), 12);
    step();
    chk("new_dx_x", sx(bus.x), 17);
    chk("new_dy_y", sx(bus.y), 9);

    // Render.
    s_en = 0; s_wxy = 1; s_x = 20; s_y = 30;
    tick();
    s_px = 27; s_py = 37;
    tick(); tick();
`ifdef GAME_SPRITE_BITMAP_EN
    exp_rgb = 0;
`else
    exp_rgb = 4;
`endif
    chk("render_27_37_rgb", int'(bus.rgb), exp_rgb);
    s_px = 28; s_py = 37;
    tick(); tick();
    chk("render_28_37_rgb", int'(bus.rgb), 0);
    s_px = 20; s_py = 30;
    tick(); tick();
    chk("render_corner_rgb", int'(bus.rgb), 4);
    chk("render_corner_on", int'(bus.sprite_on), 1);
    s_px = 20; s_py = 29;
    tick(); tick();
    chk("render_above_on", int'(bus.sprite_on), 0);

    // Reset mid-movement.
    s_en = 1; s_wdxy = 1; s_dx = 1; s_dy = 1;
    repeat (6) tick();
    s_rst = 0;
    tick();
    #1;
    chk("async_reset_x", sx(bus.x), 0);
    chk("async_reset_y", sx(bus.y), 0);
    chk("async_reset_within", int'(bus.within_screen), 1);
    chk("async_reset_rgb", int'(bus.rgb), 0);
    tick();
    s_rst = 1; s_wdxy = 1; s_dx = 2; s_dy = 2; s_en = 1;
    tick();
    repeat (3) tick();
    chk("post_reset_no_step", sx(bus.x), 0);
    tick();
    chk("post_reset_first_step", sx(bus.x), 2);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      s_rst  = ($urandom_range(0, 199) != 0);
      s_wxy  = ($urandom_range(0, 15) == 0);
      s_x    = int'($urandom_range(0, 720)) - 40;
      s_y    = int'($urandom_range(0, 560)) - 40;
      s_wdxy = ($urandom_range(0, 7) == 0);
      s_dx   = int'($urandom_range(0, 15)) - 8;
      s_dy   = int'($urandom_range(0, 15)) - 8;
      s_en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        s_px = m_x + int'($urandom_range(0, 10)) - 1;
        s_py = m_y + int'($urandom_range(0, 10)) - 1;
        if (s_px < 0) s_px = 0;
        if (s_px > 1023) s_px = 1023;
        if (s_py < 0) s_py = 0;
        if (s_py > 1023) s_py = 1023;
      end else begin
        s_px = int'($urandom_range(0, 1023));
        s_py = int'($urandom_range(0, 1023));
      end
      tick();
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/game_sprite_engine.md
# game_sprite_engine

Sprite responder: holds one sprite's position and velocity and obeys the master FSM's `write_xy`, `write_dxy` and `enable_update` commands. Moves the sprite on an internal strobe and reports `within_screen` back to the master. Renders the sprite against the display's pixel scan for the collision detector and the mixer. One instance per sprite (target, torpedo).

## Interface
- `SCREEN_W`, 640, visible width in pixels
- `SCREEN_H`, 480, visible height in pixels
- `POS_W`, 11, signed two's-complement width of x/y position
- `D_W`, 4, signed width of dx/dy velocity
- `SPRITE_W`, 8, sprite width in pixels (≤ 8)
- `SPRITE_H`, 8, sprite height in pixels (≤ 8)
- `STROBE_DIV`, 1048576, clk cycles per movement step (≥ 2)
- `RGB_W`, 3, colour width
- `SPRITE_RGB`, 3'b100, sprite colour
- `BITMAP`, 64'hFFFF_FFFF_FFFF_FFFF, row-major 8x8 mask; bit `[row*8+col]` (used only with the macro)

Ports:
- `clk` in 1: the single clock
- `reset_n` in 1: asynchronous, active-low reset
- `write_xy` in 1: load `x_init`/`y_init` into position
- `write_dxy` in 1: load `dx_init`/`dy_init` into velocity
- `enable_update` in 1: permit movement on a strobe
- `x_init`, `y_init` in POS_W: initial position, signed
- `dx_init`, `dy_init` in D_W: initial velocity, signed
- `pixel_x`, `pixel_y` in 10: current display scan coordinates
- `x`, `y` out POS_W: current position, top-left corner
- `within_screen` out 1: sprite at least partly visible
- `sprite_on` out 1: scan pixel belongs to sprite
- `rgb` out RGB_W: `SPRITE_RGB` when `sprite_on`, else 0

## Operation
- Strobe counter: free-running 0..STROBE_DIV-1, wraps to 0. `strobe` is high for one cycle when the count equals STROBE_DIV-1. The counter is never cleared by commands.
- Position next-state, in priority order:
  1. `write_xy` loads init values.
  2. Otherwise, `strobe & enable_update` sets x += sign-extended dx and y += sign-extended dy.
  3. Otherwise, position holds.
- Velocity: `write_dxy` loads dx/dy. A movement step in the same cycle uses the old velocity.
- Arithmetic: add modulo 2^POS_W; wrap is permitted and not flagged. With defaults, velocity ≤ 8 px/step keeps positions far from wrap.
- `within_screen` = (x > −SPRITE_W) & (x < SCREEN_W) & (y > −SPRITE_H) & (y < SCREEN_H), signed compare.
  - Registered from the next-state position, so it is coherent with `x`/`y` in every cycle.
- Render: `col = pixel_x − x`, `row = pixel_y − y`. Hit iff 0 ≤ col < SPRITE_W and 0 ≤ row < SPRITE_H, compared signed at POS_W+1 bits.

## Timing
- Reset values: `x`=0, `y`=0, dx=0, dy=0, strobe count 0, `within_screen`=1, `sprite_on`=0, `rgb`=0.
  - `within_screen` resets to 1 so the master sees no spurious end-of-game before its first `write_xy`.
- Commands take effect at the next rising edge. `x`/`y`/`within_screen` change in the cycle after the command or step.
- `sprite_on`/`rgb`: 1-cycle latency from `pixel_x`/`pixel_y`, independent of command timing. A position change applies from the pixel sampled after the edge it occurs on.
- `write_xy` and a step on the same edge: the load wins and the step is lost.
- `enable_update` low on a strobe cycle: the step is skipped, not deferred.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronous). After release, the first strobe comes STROBE_DIV cycles later.

## Configuration
- `GAME_SPRITE_BITMAP_EN` defined: a hit also requires `BITMAP[row*8+col]`.
- Undefined: a hit is the full SPRITE_W x SPRITE_H rectangle and `BITMAP` is ignored.

## Structure
- Shared package/header: SCREEN_W/H defaults, POS_W, RGB_W and colour constants, also used by the master FSM, collision detector and mixer.
- One sub-module, `game_strobe_gen`: parameterised by STROBE_DIV, outputs a one-cycle `strobe`. It is reusable by other timed blocks.

## Test plan
Bench uses STROBE_DIV=4 unless stated.
- Reset, then check outputs: x=y=0, within_screen=1, sprite_on=0, rgb=0. Strobe first fires on cycle 4 after release.
- write_xy (100,50), write_dxy (3,−2), enable_update=1 for 3 strobes -> x=109, y=44, each change one cycle after its strobe.
- x=636, dx=+3, step twice -> x=639 with within_screen=1, then x=642 with within_screen=0. Likewise y=−7 with dy=−1 -> within_screen drops at y=−8.
- write_xy (10,10) on a strobe cycle with enable_update=1 -> x=10, y=10, no step applied. write_dxy on a strobe -> the step uses the old dx.
- Sprite at (20,30), scan pixel (27,37) -> rgb=SPRITE_RGB next cycle. Scan pixel (28,37) -> rgb=0. With `GAME_SPRITE_BITMAP_EN` and BITMAP bit 63 cleared, (27,37) -> 0.
- Assert reset_n low mid-movement -> outputs return to reset values within the same cycle. No step occurs until 4 cycles after release.
